// File: rtl/io_input_conditioner.sv
// io_input_conditioner: synchronizes, debounces and edge-detects a pad input, buffering one edge event.
module io_input_conditioner #(
  parameter int CNT_W        = 4,
  parameter int STABLE_COUNT = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic iopad_inpad,
  input  logic cfg_enable,
  input  logic cfg_invert,
  output logic level_out,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic evt_valid,
  input  logic evt_ready,
  output logic evt_rise,
  output logic evt_overflow,
  input  logic clear_overflow
);
  generate
    if (STABLE_COUNT < 1 || STABLE_COUNT > (1 << CNT_W)) begin : g_bad_count
      $error("io_input_conditioner: STABLE_COUNT out of range 1..2^CNT_W");
    end
  endgenerate
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_COUNT - 1);
  logic s1, s2, sample, acc;
  logic [CNT_W-1:0] c;
  assign sample = s2 ^ cfg_invert;
  // acc marks the cycle a new level is accepted; the count never wraps past LAST
  assign acc = cfg_enable && sample != level_out && c == LAST;
  always_ff @(posedge clk) begin
    if (reset) begin
      s1           <= 1'b0;
      s2           <= 1'b0;
      c            <= '0;
      level_out    <= 1'b0;
      rise_pulse   <= 1'b0;
      fall_pulse   <= 1'b0;
      evt_valid    <= 1'b0;
      evt_rise     <= 1'b0;
      evt_overflow <= 1'b0;
    end else begin
      s1         <= iopad_inpad;
      s2         <= s1;
      c          <= (!cfg_enable || sample == level_out || acc) ? '0 : c + 1'b1;
      level_out  <= acc ? sample : level_out;
      rise_pulse <= acc && sample;
      fall_pulse <= acc && !sample;
      if (acc && evt_valid && !evt_ready) evt_overflow <= 1'b1;
      else if (clear_overflow) evt_overflow <= 1'b0;
      if (acc && (!evt_valid || evt_ready)) begin
        evt_valid <= 1'b1;
        evt_rise  <= sample;
      end else if (!acc && evt_valid && evt_ready) begin
        evt_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_io_input_conditioner.sv
// tb_io_input_conditioner: directed and random checks of io_input_conditioner against a behavioural model.
module tb_io_input_conditioner;
  localparam int SC = 8;
  logic clk = 1'b0;
  logic reset, iopad_inpad, cfg_enable, cfg_invert, evt_ready, clear_overflow;
  logic level_out, rise_pulse, fall_pulse, evt_valid, evt_rise, evt_overflow;
  int errors = 0;
  int checks = 0;
  logic m_l, m_rp, m_fp, m_v, m_r, m_ov;
  int m_run;
  logic q[$];

  io_input_conditioner #(.CNT_W(4), .STABLE_COUNT(SC)) dut (
    .clk(clk), .reset(reset), .iopad_inpad(iopad_inpad), .cfg_enable(cfg_enable),
    .cfg_invert(cfg_invert), .level_out(level_out), .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse), .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_rise(evt_rise), .evt_overflow(evt_overflow), .clear_overflow(clear_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Model: the pad seen two edges ago is the debounced candidate; a level is
  // accepted once it has differed from the held level for SC enabled edges in a row.
  task automatic step();
    logic smp, edge_now;
    @(posedge clk);
    if (reset) begin
      q = '{1'b0, 1'b0};
      m_l = 0; m_rp = 0; m_fp = 0; m_v = 0; m_r = 0; m_ov = 0; m_run = 0;
    end else begin
      smp = q[0] ^ cfg_invert;
      edge_now = 1'b0;
      if (!cfg_enable || smp == m_l) m_run = 0;
      else begin
        m_run++;
        if (m_run == SC) begin
          edge_now = 1'b1;
          m_l = smp;
          m_run = 0;
        end
      end
      if (edge_now && m_v && !evt_ready) m_ov = 1'b1;
      else if (clear_overflow) m_ov = 1'b0;
      if (edge_now) begin
        if (!m_v || evt_ready) begin
          m_v = 1'b1;
          m_r = smp;
        end
      end else if (m_v && evt_ready) m_v = 1'b0;
      m_rp = edge_now && smp;
      m_fp = edge_now && !smp;
      q.push_back(iopad_inpad);
      void'(q.pop_front());
    end
    #1;
    chk("level_out", level_out, m_l);
    chk("rise_pulse", rise_pulse, m_rp);
    chk("fall_pulse", fall_pulse, m_fp);
    chk("evt_valid", evt_valid, m_v);
    chk("evt_rise", evt_rise, m_r);
    chk("evt_overflow", evt_overflow, m_ov);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    q = '{1'b0, 1'b0};
    m_l = 0; m_rp = 0; m_fp = 0; m_v = 0; m_r = 0; m_ov = 0; m_run = 0;
    reset = 1; iopad_inpad = 0; cfg_enable = 0; cfg_invert = 0; evt_ready = 0; clear_overflow = 0;
    run(2);
    chk("reset_level", level_out, 1'b0);
    chk("reset_valid", evt_valid, 1'b0);
    chk("reset_ovf", evt_overflow, 1'b0);
    reset = 0; cfg_enable = 1;
    // rise latency 2+SC
    iopad_inpad = 1;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (i == 9) chk("rise_lat_early", level_out, 1'b0);
      if (i == 10) begin
        chk("rise_lat_level", level_out, 1'b1);
        chk("rise_lat_pulse", rise_pulse, 1'b1);
      end
    end
    step();
    chk("rise_pulse_once", rise_pulse, 1'b0);
    chk("rise_evt_valid", evt_valid, 1'b1);
    chk("rise_evt_type", evt_rise, 1'b1);
    evt_ready = 1; step(); evt_ready = 0;
    // glitches of 1 and 7 cycles
    reset = 1; iopad_inpad = 0; step(); reset = 0; run(4);
    iopad_inpad = 1; step(); iopad_inpad = 0; run(12);
    iopad_inpad = 1; run(7); iopad_inpad = 0; run(12);
    chk("glitch_level", level_out, 1'b0);
    chk("glitch_evt", evt_valid, 1'b0);
    // overflow with stalled consumer
    iopad_inpad = 1; run(10);
    iopad_inpad = 0; run(10);
    chk("ovf_flag", evt_overflow, 1'b1);
    chk("ovf_valid", evt_valid, 1'b1);
    chk("ovf_kept_rise", evt_rise, 1'b1);
    evt_ready = 1; step(); evt_ready = 0;
    chk("ovf_drain", evt_valid, 1'b0);
    clear_overflow = 1; step(); clear_overflow = 0;
    chk("ovf_clear", evt_overflow, 1'b0);
    // reload on simultaneous accept and new edge
    iopad_inpad = 1; run(10);
    iopad_inpad = 0; run(9);
    evt_ready = 1; step();
    chk("reload_valid", evt_valid, 1'b1);
    chk("reload_type", evt_rise, 1'b0);
    chk("reload_no_ovf", evt_overflow, 1'b0);
    step(); evt_ready = 0;
    // reset mid-count
    iopad_inpad = 1; run(7);
    reset = 1; step(); reset = 0;
    chk("midreset_level", level_out, 1'b0);
    chk("midreset_pulse", rise_pulse, 1'b0);
    for (int i = 1; i <= 10; i++) begin
      step();
      if (i == 9) chk("post_reset_early", level_out, 1'b0);
      if (i == 10) chk("post_reset_rise", rise_pulse, 1'b1);
    end
    evt_ready = 1; step(); evt_ready = 0;
    // disable holds; re-enable and invert take SC cycles
    cfg_enable = 0; iopad_inpad = 0; run(15);
    chk("disabled_hold", level_out, 1'b1);
    cfg_enable = 1;
    for (int i = 1; i <= SC; i++) begin
      step();
      if (i == SC - 1) chk("reenable_early", level_out, 1'b1);
      if (i == SC) chk("reenable_fall", fall_pulse, 1'b1);
    end
    cfg_invert = 1;
    for (int i = 1; i <= SC; i++) begin
      step();
      if (i == SC) chk("invert_rise", rise_pulse, 1'b1);
    end
    cfg_invert = 0; evt_ready = 1; run(12);
    // random traffic
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(5) == 0) iopad_inpad = ~iopad_inpad;
      evt_ready = ($urandom_range(3) == 0);
      clear_overflow = ($urandom_range(15) == 0);
      cfg_enable = ($urandom_range(19) != 0);
      if ($urandom_range(99) == 0) cfg_invert = ~cfg_invert;
      reset = ($urandom_range(199) == 0);
      step();
      if (i % 60 == 0) run($urandom_range(SC + 4));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
